// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared widths, score type and tracker state encoding
//
// Purpose: common definitions for the Smith-Waterman cell array and its
// downstream max tracker.
//   SCORE_W        signed cell score width
//   POS_W          row/column index and length width
//   score_t        signed score type
//   sw_trk_state_t tracker FSM states
package sw_pkg;

    localparam int SCORE_W = 8;
    localparam int POS_W   = 10;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sw_trk_state_t;

endpackage

// File: rtl/sw_pos_counter.sv
// rtl/sw_pos_counter.sv - row-major row/column position counter
//
// Purpose: tracks the matrix position of the next accepted cell score.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          return to row 0, column 0
//   inc          advance one column, wrapping into the next row
//   s_len, q_len matrix dimensions (columns, rows)
//   row, col     current position
//   last         current position is the final cell (q_len-1, s_len-1)
module sw_pos_counter #(
    parameter int POS_W = sw_pkg::POS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [POS_W-1:0] s_len,
    input  logic [POS_W-1:0] q_len,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic             last
);

    localparam logic [POS_W-1:0] ONE = POS_W'(1);

    logic col_wrap;

    assign col_wrap = (col == s_len - ONE);
    assign last     = (row == q_len - ONE) && col_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: rtl/sw_max_tracker.sv
// rtl/sw_max_tracker.sv - running max score, position and threshold hit tracker
//
// Purpose: consumes one alignment's cell scores in row-major order, keeps the
// largest score with its position and a sticky threshold-hit flag, and offers
// the result through a valid/ready handshake.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, q_len, s_len, threshold alignment launch and its parameters
//   score_valid, score, score_ready   score stream
//   result_valid, result_ready        result handshake
//   max_score, max_q_pos, max_s_pos   best score and its (row, column)
//   hit                               some score reached the threshold
//   busy                              tracker not idle
module sw_max_tracker #(
    parameter int SCORE_W = sw_pkg::SCORE_W,
    parameter int POS_W   = sw_pkg::POS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [POS_W-1:0]   q_len,
    input  logic [POS_W-1:0]   s_len,
    input  logic [SCORE_W-1:0] threshold,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score,
    output logic               score_ready,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [SCORE_W-1:0] max_score,
    output logic [POS_W-1:0]   max_q_pos,
    output logic [POS_W-1:0]   max_s_pos,
    output logic               hit,
    output logic               busy
);

    import sw_pkg::*;

    sw_trk_state_t state, next_state;

    logic [POS_W-1:0]          q_len_r;
    logic [POS_W-1:0]          s_len_r;
    logic signed [SCORE_W-1:0] thr_r;

    logic             accept_start;
    logic             xfer;
    logic             cnt_last;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;

    assign accept_start = (state == IDLE) && start;
    assign xfer         = score_valid && score_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs decode only the state register.
    always_comb begin
        next_state   = state;
        score_ready  = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // An empty matrix has no cells to wait for.
                    if (q_len == '0 || s_len == '0) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                score_ready = 1'b1;
                busy        = 1'b1;
                if (score_valid && cnt_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                result_valid = 1'b1;
                busy         = 1'b1;
                if (result_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_len_r   <= '0;
            s_len_r   <= '0;
            thr_r     <= '0;
            max_score <= '0;
            max_q_pos <= '0;
            max_s_pos <= '0;
            hit       <= 1'b0;
        end else if (accept_start) begin
            q_len_r   <= q_len;
            s_len_r   <= s_len;
            thr_r     <= $signed(threshold);
            max_score <= '0;
            max_q_pos <= '0;
            max_s_pos <= '0;
            hit       <= 1'b0;
        end else if (xfer) begin
            // Strict compare keeps the earliest position on ties; starting
            // from 0 means negative scores never win.
            if ($signed(score) > $signed(max_score)) begin
                max_score <= score;
                max_q_pos <= row;
                max_s_pos <= col;
            end
            if ($signed(score) >= thr_r) begin
                hit <= 1'b1;
            end
        end
    end

    sw_pos_counter #(
        .POS_W (POS_W)
    ) u_pos_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept_start),
        .inc   (xfer),
        .s_len (s_len_r),
        .q_len (q_len_r),
        .row   (row),
        .col   (col),
        .last  (cnt_last)
    );

endmodule

// File: tb/tb_sw_max_tracker.sv
// tb/tb_sw_max_tracker.sv - self-checking bench for sw_max_tracker
module tb_sw_max_tracker;

    localparam int SW = 8;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] q_len;
    logic [PW-1:0] s_len;
    logic [SW-1:0] threshold;
    logic          score_valid;
    logic [SW-1:0] score;
    logic          score_ready;
    logic          result_valid;
    logic          result_ready;
    logic [SW-1:0] max_score;
    logic [PW-1:0] max_q_pos;
    logic [PW-1:0] max_s_pos;
    logic          hit;
    logic          busy;

    sw_max_tracker #(.SCORE_W(SW), .POS_W(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .q_len        (q_len),
        .s_len        (s_len),
        .threshold    (threshold),
        .score_valid  (score_valid),
        .score        (score),
        .score_ready  (score_ready),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .max_score    (max_score),
        .max_q_pos    (max_q_pos),
        .max_s_pos    (max_s_pos),
        .hit          (hit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 collecting scores, 2 result offered.
    // The best position is derived from the cell's row-major index.
    int m_ph = 0;
    int m_q, m_s, m_thr, m_cnt, m_v;
    int m_max = 0, m_qp = 0, m_sp = 0, m_hit = 0;
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_max = 0; m_qp = 0; m_sp = 0; m_hit = 0; m_ok = 1'b1;
        end else begin
            case (m_ph)
                0: if (start) begin
                    m_q = int'(q_len); m_s = int'(s_len);
                    m_thr = $signed(threshold);
                    m_max = 0; m_qp = 0; m_sp = 0; m_hit = 0; m_cnt = 0;
                    m_ph = (m_q == 0 || m_s == 0) ? 2 : 1;
                end
                1: if (score_valid) begin
                    m_v = $signed(score);
                    if (m_v > m_max) begin
                        m_max = m_v; m_qp = m_cnt / m_s; m_sp = m_cnt % m_s;
                    end
                    if (m_v >= m_thr) m_hit = 1;
                    m_cnt++;
                    if (m_cnt == m_q * m_s) m_ph = 2;
                end
                default: if (result_ready) m_ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("score_ready", score_ready, m_ph == 1);
            check("result_valid", result_valid, m_ph == 2);
            check("busy", busy, m_ph != 0);
            check("max_score", $signed(max_score), m_max);
            check("max_q_pos", max_q_pos, m_qp);
            check("max_s_pos", max_s_pos, m_sp);
            check("hit", hit, m_hit);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_align(input int ql, input int sl, input int thr);
        start = 1'b1;
        q_len = PW'(ql);
        s_len = PW'(sl);
        threshold = SW'(thr);
        tick();
        start = 1'b0;
    endtask

    // Random stalls; during stalls a stray start pulse may appear and must be ignored.
    task automatic feed(input int sc[$], input int stall_pct);
        foreach (sc[i]) begin
            while (int'($urandom_range(99)) < stall_pct) begin
                score_valid = 1'b0;
                score = SW'($urandom);
                start = ($urandom_range(7) == 0);
                q_len = PW'($urandom_range(3));
                tick();
                start = 1'b0;
            end
            score_valid = 1'b1;
            score = SW'(sc[i]);
            tick();
        end
        score_valid = 1'b0;
    endtask

    // Wait for the result, hold result_ready low for delay cycles, then release.
    task automatic finish(input string name, input int delay, input bit lit,
                          input int e_max, input int e_qp, input int e_sp, input int e_hit);
        int w = 0;
        while (!result_valid && w < 40) begin
            tick();
            w++;
        end
        check({name, "_valid"}, result_valid, 1);
        if (lit) begin
            check({name, "_max"}, $signed(max_score), e_max);
            check({name, "_qpos"}, max_q_pos, e_qp);
            check({name, "_spos"}, max_s_pos, e_sp);
            check({name, "_hit"}, hit, e_hit);
        end
        for (int d = 0; d < delay; d++) begin
            score_valid = $urandom_range(1);
            score = SW'($urandom);
            start = $urandom_range(1);
            tick();
        end
        score_valid = 1'b0;
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sc[$];
        int ql, sl;
        rst = 1'b1; start = 1'b0; q_len = '0; s_len = '0; threshold = '0;
        score_valid = 1'b0; score = '0; result_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_ready", score_ready, 0);
        check("reset_valid", result_valid, 0);
        check("reset_max", $signed(max_score), 0);
        check("reset_hit", hit, 0);

        // Basic max with 5-cycle backpressure in DONE.
        begin_align(2, 3, 5);
        check("basic_busy", busy, 1);
        sc = '{0, 2, 1, 3, 1, 0};
        feed(sc, 0);
        check("basic_latency", result_valid, 1);
        finish("basic", 5, 1'b1, 3, 1, 0, 0);

        // Tie keeps earliest position; threshold reached.
        begin_align(1, 4, 2);
        sc = '{2, 1, 2, 0};
        feed(sc, 0);
        finish("tie", 0, 1'b1, 2, 0, 0, 1);

        // All negative scores leave max at the floor.
        begin_align(2, 2, 1);
        sc = '{-1, -1, -2, -1};
        feed(sc, 0);
        finish("neg", 1, 1'b1, 0, 0, 0, 0);

        // Stall pattern 1,0,0,1,1,0,1 with a stray start mid-run.
        begin_align(2, 2, 10);
        score_valid = 1'b1; score = SW'(1); tick();
        score_valid = 1'b0; start = 1'b1; q_len = '0; tick();
        start = 1'b0; tick();
        score_valid = 1'b1; score = SW'(4); tick();
        score = SW'(2); tick();
        score_valid = 1'b0; tick();
        score_valid = 1'b1; score = SW'(3); tick();
        score_valid = 1'b0;
        finish("stall", 0, 1'b1, 4, 0, 1, 0);

        // Zero length: result in the next cycle.
        begin_align(0, 3, -5);
        check("zero_valid_n1", result_valid, 1);
        finish("zero", 2, 1'b1, 0, 0, 0, 0);

        // Reset after 3 of 6 transfers discards the partial result.
        begin_align(2, 3, 0);
        sc = '{5, 6, 7};
        feed(sc, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_max", $signed(max_score), 0);
        check("rst_qpos", max_q_pos, 0);
        check("rst_hit", hit, 0);

        // Randomised alignments.
        for (int n = 0; n < 40; n++) begin
            ql = $urandom_range(0, 4);
            sl = $urandom_range(0, 5);
            sc.delete();
            for (int k = 0; k < ql * sl; k++) sc.push_back(int'($urandom_range(0, 255)) - 128);
            repeat ($urandom_range(0, 2)) tick();
            begin_align(ql, sl, int'($urandom_range(0, 255)) - 128);
            feed(sc, 30);
            finish("rand", $urandom_range(0, 3), 1'b0, 0, 0, 0, 0);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_max_tracker.md
# sw_max_tracker

Downstream stage of the Smith-Waterman `Cell` array in the BLAST-N alignment core. It consumes the stream of cell scores produced for one query/subject alignment in row-major order (query row, subject column). It tracks the running maximum score and its matrix position, and flags any score that reaches a programmable threshold. When the alignment completes, it presents the result through a valid/ready handshake.

## Interface
Parameters:
- `SCORE_W`, 8: signed score width; must equal the array's score width.
- `POS_W`, 10: width of the row/column indices and lengths.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse that begins an alignment; sampled only in IDLE.
- `q_len`  in  POS_W  query length in rows; captured on `start`.
- `s_len`  in  POS_W  subject length in columns; captured on `start`.
- `threshold`  in  SCORE_W  signed hit threshold; captured on `start`.
- `score_valid`  in  1  `score` is valid.
- `score`  in  SCORE_W  signed cell score.
- `score_ready`  out  1  block accepts a score this cycle.
- `result_valid`  out  1  result outputs are valid.
- `result_ready`  in  1  consumer accepts the result.
- `max_score`  out  SCORE_W  largest score seen.
- `max_q_pos`  out  POS_W  row of `max_score`.
- `max_s_pos`  out  POS_W  column of `max_score`.
- `hit`  out  1  at least one score was ≥ `threshold`.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - On `start`, capture `q_len`, `s_len` and `threshold`.
  - Clear `max_score`, `max_q_pos`, `max_s_pos` and `hit` to 0. Clear the row and column counters.
  - Go to RUN. If `q_len`==0 or `s_len`==0, go to DONE instead.
- **RUN**
  - `score_ready`=1.
  - A transfer occurs when `score_valid && score_ready`.
  - On each transfer:
    - If `score` > `max_score` (signed, strict), update `max_score` and latch the current row/column into `max_q_pos`/`max_s_pos`. The strict compare means ties keep the earliest position in row-major order.
    - If `score` ≥ `threshold` (signed), set `hit`. `hit` is sticky until the next `start`.
    - Advance the column counter. When the column equals `s_len`-1, wrap it to 0 and increment the row.
  - The transfer at row `q_len`-1 and column `s_len`-1 moves the FSM to DONE.
- **DONE**
  - `result_valid`=1 and `score_ready`=0.
  - Hold all result outputs stable.
  - When `result_ready` is high, go to IDLE.
- `start` outside IDLE is ignored.
- `score_valid` outside RUN is ignored and never alters state.
- Negative scores are legal inputs. Because `max_score` is initialised to 0, a negative score never updates it; this is the Smith-Waterman floor.
- Result outputs keep their values in IDLE until the next accepted `start`.

## Timing
- Reset values:
  - state: IDLE.
  - `score_ready`, `result_valid`, `busy`, `hit`: 0.
  - `max_score`, `max_q_pos`, `max_s_pos`: 0.
- Reset mid-RUN or mid-DONE returns the block to IDLE on the next edge. The partial result is discarded.
- `start` sampled at edge N: `busy` and `score_ready` are 1 from cycle N+1.
- Last transfer at edge M: `result_valid`=1 from cycle M+1. The outputs include that last score's contribution, so latency is 1 cycle.
- Zero length: `start` at edge N gives `result_valid` at N+1 with `max_score`=0 and `hit`=0.
- `result_valid && result_ready` at edge K: IDLE at K+1. A `start` in cycle K+1 is accepted.
- Throughput is one score per cycle with no bubbles. `score_valid` may be deasserted for any number of cycles without losing position.
- All outputs are registered. There are no combinational paths from inputs to outputs except `score_ready`, which depends only on state.

## Structure
- Shared package `sw_pkg`:
  - `SCORE_W` and `POS_W` defaults, shared with `Cell` and the array.
  - State enum `sw_trk_state_t` {IDLE, RUN, DONE}.
  - Signed score typedef `score_t`.
- One sub-module, `sw_pos_counter`: the row/column counter pair.
  - Inputs: `clr`, `inc`, `s_len`, `q_len`.
  - Outputs: `row`, `col`, `last` (high at row `q_len`-1, column `s_len`-1).

## Test plan
- **Basic max:** `q_len`=2, `s_len`=3, `threshold`=5, scores 0,2,1,3,1,0 → `result_valid` one cycle after the sixth transfer; `max_score`=3, `max_q_pos`=1, `max_s_pos`=0, `hit`=0.
- **Tie and threshold:** `q_len`=1, `s_len`=4, `threshold`=2, scores 2,1,2,0 → `max_score`=2 at (0,0), `hit`=1.
- **All negative:** `q_len`=2, `s_len`=2, scores -1,-1,-2,-1 → `max_score`=0 at (0,0), `hit`=0 with `threshold`=1.
- **Stalls:** `score_valid` toggled 1,0,0,1,1,0,1 over four scores 1,4,2,3 with `q_len`=2, `s_len`=2 → `max_score`=4 at (0,1). `start` pulsed mid-RUN is ignored.
- **Backpressure:** `result_ready` held low for 5 cycles in DONE → `result_valid` and the outputs are stable throughout. IDLE one cycle after `result_ready` rises.
- **Zero length and reset:** `q_len`=0 → `result_valid` at N+1 with `max_score`=0. Separately, `rst` asserted after 3 of 6 transfers → IDLE and all outputs 0 on the next cycle.
